ex_ma_reg: RTL and testbench
============================

// Module: ex_ma_reg
// PURPOSE
//  EX->MA pipeline register of the 5-stage core. Captures EX-stage results and control each cycle.
//  Presents the branch flags, less, zero and addr_sel, to the Flush unit, and the redirect PC to fetch.
//  Supports stall (hold), flush (bubble insert) and a valid bit. A bubble never requests a redirect.
// PARAMETERS
//  XLEN       32  datapath width
//  RA_W       5   register-address width
//  CNT_W      32  perf-counter width (only used with EXMA_PERF_CNT_EN)
// PORTS
//  clk              in   1     rising-edge clock
//  rstn             in   1     asynchronous active-low reset
//  stall_in         in   1     hazard unit: hold register contents
//  flush_in         in   1     Flush unit: load bubble on next edge
//  ex_valid         in   1     EX holds a real instruction
//  ex_less          in   1     ALU less-than flag
//  ex_zero          in   1     ALU zero flag
//  ex_addr_sel      in   3     0 seq, 1 blt, 2 beq, 3 jal, 4 jalr
//  ex_alu_result    in   XLEN  ALU result, also the jalr target
//  ex_branch_target in   XLEN  pc+imm for blt/beq/jal
//  ex_pc_plus4      in   XLEN  link value
//  ex_rs2_data      in   XLEN  store data
//  ex_rd            in   RA_W  destination register
//  ex_reg_write     in   1     writeback enable
//  ex_mem_read      in   1     load
//  ex_mem_write     in   1     store
//  ex_wb_sel        in   2     0 alu, 1 mem, 2 pc+4
//  ma_valid         out  1     MA holds a real instruction
//  less_out         out  1     to Flush
//  zero_out         out  1     to Flush
//  addr_sel_out     out  3     to Flush; forced to 0 when ma_valid=0
//  redirect_pc      out  XLEN  jalr: alu_result & ~1; else branch_target
//  ma_alu_result, ma_pc_plus4, ma_rs2_data  out XLEN; ma_rd out RA_W
//  ma_reg_write, ma_mem_read, ma_mem_write  out 1; ma_wb_sel out 2
//  perf_redirects   out  CNT_W  (EXMA_PERF_CNT_EN only)
//  perf_stalls      out  CNT_W  (EXMA_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset (rstn=0, async): every registered output is 0, including ma_valid, all control, data and counters.
//  - Per rising edge, in priority order:
//    1. flush_in=1: load bubble. ma_valid, reg_write, mem_read, mem_write, addr_sel, less, zero and wb_sel
//       all go to 0. Data fields may be any value; they are cleared to 0 here.
//    2. stall_in=1: hold every field.
//    3. Otherwise: load all ex_* fields. ma_valid <= ex_valid.
//       If ex_valid=0, control fields (reg_write, mem_*, addr_sel) load as 0.
//  - flush_in and stall_in together: flush wins and a bubble is loaded.
//  - Latency 1 cycle, EX to MA. No combinational path from ex_* to any output.
//  - addr_sel_out, less_out and zero_out come straight from the register, gated by ma_valid.
//    Flush therefore fires for exactly one cycle per taken branch. The bubble loaded on that edge clears it.
//  - redirect_pc is combinational from registered fields. For jalr, bit0 is forced to 0.
//  - A stall held on a taken branch keeps flush asserted. Flush has priority, so the next edge still bubbles.
//  - Deassertion of rstn is synchronous to clk in the top level. This block needs no extra sync.
// CONFIGURATION
//  - EXMA_PERF_CNT_EN defined:
//    - perf_redirects +1 on each edge where flush_in=1.
//    - perf_stalls +1 on each edge where stall_in=1 and flush_in=0.
//    - Both wrap modulo 2^CNT_W and reset to 0.
//  - EXMA_PERF_CNT_EN undefined: perf ports are absent and no counter flops are built.
// TESTING
//  - Reset mid-run: load add with rd=5, then pulse rstn low between edges.
//    Required: all outputs are 0 immediately, without waiting for a clock.
//  - Plain load: ex_valid=1, alu=0x10, rd=3, reg_write=1.
//    Required: next cycle ma_alu_result=0x10, ma_rd=3, ma_valid=1.
//  - Taken beq: addr_sel=2, zero=1, target=0x40.
//    Required: cycle+1 addr_sel_out=2 and redirect_pc=0x40. With flush_in=1, cycle+2 ma_valid=0 and addr_sel_out=0.
//  - jalr: alu=0x1003. Required: redirect_pc=0x1002 and ma_pc_plus4 kept.
//  - Stall 3 cycles with ex_* toggling. Required: outputs are unchanged. Stall+flush in the same cycle gives a bubble.
//  - Bubble input: ex_valid=0, addr_sel=3. Required: addr_sel_out=0 and no redirect.
//  - EXMA_PERF_CNT_EN: 2 flushes and 3 stalls. Required: perf_redirects=2, perf_stalls=3.
//    With CNT_W=2, 4 flushes wrap perf_redirects to 0.

Source files
------------

// File: rtl/ex_ma_reg.sv
// EX->MA pipeline register: captures EX results/control with stall, flush and valid handling.
// Optional performance counters are built only when EXMA_PERF_CNT_EN is defined.
module ex_ma_reg #(
   parameter int XLEN = 32,
   parameter int RA_W = 5
`ifdef EXMA_PERF_CNT_EN
   ,
   parameter int CNT_W = 32
`endif
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            stall_in,
   input  logic            flush_in,
   input  logic            ex_valid,
   input  logic            ex_less,
   input  logic            ex_zero,
   input  logic [2:0]      ex_addr_sel,
   input  logic [XLEN-1:0] ex_alu_result,
   input  logic [XLEN-1:0] ex_branch_target,
   input  logic [XLEN-1:0] ex_pc_plus4,
   input  logic [XLEN-1:0] ex_rs2_data,
   input  logic [RA_W-1:0] ex_rd,
   input  logic            ex_reg_write,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic [1:0]      ex_wb_sel,
   output logic            ma_valid,
   output logic            less_out,
   output logic            zero_out,
   output logic [2:0]      addr_sel_out,
   output logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] ma_alu_result,
   output logic [XLEN-1:0] ma_pc_plus4,
   output logic [XLEN-1:0] ma_rs2_data,
   output logic [RA_W-1:0] ma_rd,
   output logic            ma_reg_write,
   output logic            ma_mem_read,
   output logic            ma_mem_write,
   output logic [1:0]      ma_wb_sel
`ifdef EXMA_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_redirects,
   output logic [CNT_W-1:0] perf_stalls
`endif
);

   localparam logic [2:0] SEL_JALR = 3'd4;

   typedef struct packed {
      logic            valid;
      logic            less;
      logic            zero;
      logic [2:0]      addr_sel;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] branch_target;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] rs2_data;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [1:0]      wb_sel;
   } stage_t;

   stage_t stage_q, stage_d;

   // Flush beats stall; an invalid EX slot loads with its side-effecting controls cleared.
   always_comb begin
      stage_d = stage_q;
      if (flush_in) begin
         stage_d = '0;
      end else if (stall_in) begin
         stage_d = stage_q;
      end else begin
         stage_d.valid         = ex_valid;
         stage_d.less          = ex_less;
         stage_d.zero          = ex_zero;
         stage_d.addr_sel      = ex_valid ? ex_addr_sel : 3'd0;
         stage_d.alu_result    = ex_alu_result;
         stage_d.branch_target = ex_branch_target;
         stage_d.pc_plus4      = ex_pc_plus4;
         stage_d.rs2_data      = ex_rs2_data;
         stage_d.rd            = ex_rd;
         stage_d.reg_write     = ex_valid & ex_reg_write;
         stage_d.mem_read      = ex_valid & ex_mem_read;
         stage_d.mem_write     = ex_valid & ex_mem_write;
         stage_d.wb_sel        = ex_wb_sel;
      end
   end

   // Stage register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Branch flags are qualified by valid so a bubble can never request a redirect.
   assign ma_valid      = stage_q.valid;
   assign less_out      = stage_q.valid & stage_q.less;
   assign zero_out      = stage_q.valid & stage_q.zero;
   assign addr_sel_out  = stage_q.valid ? stage_q.addr_sel : 3'd0;
   assign redirect_pc   = (stage_q.addr_sel == SEL_JALR) ?
                          {stage_q.alu_result[XLEN-1:1], 1'b0} : stage_q.branch_target;
   assign ma_alu_result = stage_q.alu_result;
   assign ma_pc_plus4   = stage_q.pc_plus4;
   assign ma_rs2_data   = stage_q.rs2_data;
   assign ma_rd         = stage_q.rd;
   assign ma_reg_write  = stage_q.reg_write;
   assign ma_mem_read   = stage_q.mem_read;
   assign ma_mem_write  = stage_q.mem_write;
   assign ma_wb_sel     = stage_q.wb_sel;

`ifdef EXMA_PERF_CNT_EN
   logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // A stall only counts when it actually holds the register (flush not overriding it).
   always_comb begin
      redir_cnt_d = redir_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (flush_in) begin
         redir_cnt_d = redir_cnt_q + CNT_W'(1);
      end else if (stall_in) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         redir_cnt_d = redir_cnt_q;
      end
   end

   // Counter registers, wrapping naturally.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         redir_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         redir_cnt_q <= redir_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_redirects = redir_cnt_q;
   assign perf_stalls    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_ma_reg.sv
// Self-checking bench for ex_ma_reg: directed scenarios plus randomized stall/flush traffic
// compared against a transaction-level reference model.
module tb_ex_ma_reg;
   localparam int XLEN = 32;
   localparam int RA_W = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn, stall_in, flush_in, ex_valid, ex_less, ex_zero;
   logic [2:0] ex_addr_sel;
   logic [XLEN-1:0] ex_alu_result, ex_branch_target, ex_pc_plus4, ex_rs2_data;
   logic [RA_W-1:0] ex_rd;
   logic ex_reg_write, ex_mem_read, ex_mem_write;
   logic [1:0] ex_wb_sel;

   logic ma_valid, less_out, zero_out;
   logic [2:0] addr_sel_out;
   logic [XLEN-1:0] redirect_pc, ma_alu_result, ma_pc_plus4, ma_rs2_data;
   logic [RA_W-1:0] ma_rd;
   logic ma_reg_write, ma_mem_read, ma_mem_write;
   logic [1:0] ma_wb_sel;

   int checks = 0;
   int errors = 0;

`ifdef EXMA_PERF_CNT_EN
   logic [31:0] perf_redirects, perf_stalls;
   logic [1:0]  perf_redirects2, perf_stalls2;
`endif

   ex_ma_reg #(.XLEN(XLEN), .RA_W(RA_W)) u_dut (
      .clk(clk), .rstn(rstn), .stall_in(stall_in), .flush_in(flush_in),
      .ex_valid(ex_valid), .ex_less(ex_less), .ex_zero(ex_zero), .ex_addr_sel(ex_addr_sel),
      .ex_alu_result(ex_alu_result), .ex_branch_target(ex_branch_target),
      .ex_pc_plus4(ex_pc_plus4), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_wb_sel(ex_wb_sel),
      .ma_valid(ma_valid), .less_out(less_out), .zero_out(zero_out),
      .addr_sel_out(addr_sel_out), .redirect_pc(redirect_pc),
      .ma_alu_result(ma_alu_result), .ma_pc_plus4(ma_pc_plus4), .ma_rs2_data(ma_rs2_data),
      .ma_rd(ma_rd), .ma_reg_write(ma_reg_write), .ma_mem_read(ma_mem_read),
      .ma_mem_write(ma_mem_write), .ma_wb_sel(ma_wb_sel)
`ifdef EXMA_PERF_CNT_EN
      , .perf_redirects(perf_redirects), .perf_stalls(perf_stalls)
`endif
   );

`ifdef EXMA_PERF_CNT_EN
   logic ma_valid2, less_out2, zero_out2;
   logic [2:0] addr_sel_out2;
   logic [XLEN-1:0] redirect_pc2, ma_alu_result2, ma_pc_plus42, ma_rs2_data2;
   logic [RA_W-1:0] ma_rd2;
   logic ma_reg_write2, ma_mem_read2, ma_mem_write2;
   logic [1:0] ma_wb_sel2;

   ex_ma_reg #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(2)) u_dut_narrow (
      .clk(clk), .rstn(rstn), .stall_in(stall_in), .flush_in(flush_in),
      .ex_valid(ex_valid), .ex_less(ex_less), .ex_zero(ex_zero), .ex_addr_sel(ex_addr_sel),
      .ex_alu_result(ex_alu_result), .ex_branch_target(ex_branch_target),
      .ex_pc_plus4(ex_pc_plus4), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_wb_sel(ex_wb_sel),
      .ma_valid(ma_valid2), .less_out(less_out2), .zero_out(zero_out2),
      .addr_sel_out(addr_sel_out2), .redirect_pc(redirect_pc2),
      .ma_alu_result(ma_alu_result2), .ma_pc_plus4(ma_pc_plus42), .ma_rs2_data(ma_rs2_data2),
      .ma_rd(ma_rd2), .ma_reg_write(ma_reg_write2), .ma_mem_read(ma_mem_read2),
      .ma_mem_write(ma_mem_write2), .ma_wb_sel(ma_wb_sel2),
      .perf_redirects(perf_redirects2), .perf_stalls(perf_stalls2)
   );
`endif

   // Reference model: the instruction currently sitting in MA, plus event tallies.
   logic m_valid, m_less, m_zero;
   logic [2:0] m_sel;
   logic [XLEN-1:0] m_alu, m_tgt, m_pc4, m_rs2;
   logic [RA_W-1:0] m_rd;
   logic m_rw, m_mr, m_mw;
   logic [1:0] m_wb;
   int unsigned m_redir, m_stall;

   task automatic model_bubble();
      m_valid = 1'b0; m_less = 1'b0; m_zero = 1'b0; m_sel = 3'd0;
      m_alu = '0; m_tgt = '0; m_pc4 = '0; m_rs2 = '0; m_rd = '0;
      m_rw = 1'b0; m_mr = 1'b0; m_mw = 1'b0; m_wb = 2'd0;
   endtask

   task automatic model_edge();
      if (flush_in) begin
         model_bubble();
         m_redir++;
      end else if (stall_in) begin
         m_stall++;
      end else begin
         m_valid = ex_valid; m_less = ex_less; m_zero = ex_zero;
         m_sel = ex_valid ? ex_addr_sel : 3'd0;
         m_alu = ex_alu_result; m_tgt = ex_branch_target;
         m_pc4 = ex_pc_plus4; m_rs2 = ex_rs2_data; m_rd = ex_rd;
         m_rw = ex_valid & ex_reg_write; m_mr = ex_valid & ex_mem_read;
         m_mw = ex_valid & ex_mem_write; m_wb = ex_wb_sel;
      end
   endtask

   function automatic logic [143:0] exp_vec();
      logic [XLEN-1:0] tgt;
      tgt = (m_sel == 3'd4) ? (m_alu & 32'hFFFF_FFFE) : m_tgt;
      return {m_valid, m_valid & m_less, m_valid & m_zero, m_valid ? m_sel : 3'd0, tgt,
              m_alu, m_pc4, m_rs2, m_rd, m_rw, m_mr, m_mw, m_wb};
   endfunction

   logic [143:0] obs_vec;
   assign obs_vec = {ma_valid, less_out, zero_out, addr_sel_out, redirect_pc,
                     ma_alu_result, ma_pc_plus4, ma_rs2_data, ma_rd,
                     ma_reg_write, ma_mem_read, ma_mem_write, ma_wb_sel};

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive_random_ex();
      ex_valid = 1'($urandom); ex_less = 1'($urandom); ex_zero = 1'($urandom);
      ex_addr_sel = 3'($urandom_range(0, 4));
      ex_alu_result = $urandom; ex_branch_target = $urandom;
      ex_pc_plus4 = $urandom; ex_rs2_data = $urandom; ex_rd = 5'($urandom);
      ex_reg_write = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_mem_write = 1'($urandom); ex_wb_sel = 2'($urandom_range(0, 2));
   endtask

   task automatic drive_clear_ex();
      ex_valid = 1'b0; ex_less = 1'b0; ex_zero = 1'b0; ex_addr_sel = 3'd0;
      ex_alu_result = '0; ex_branch_target = '0; ex_pc_plus4 = '0; ex_rs2_data = '0;
      ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      ex_wb_sel = 2'd0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; stall_in = 1'b0; flush_in = 1'b0;
      drive_random_ex();
      model_bubble(); m_redir = 0; m_stall = 0;
      #2;
      checks++;
      if (obs_vec !== 144'd0) begin
         errors++; $display("FAIL reset_outputs got %h want 0", obs_vec);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_plain_load();
      drive_clear_ex();
      ex_valid = 1'b1; ex_alu_result = 32'h10; ex_rd = 5'd3; ex_reg_write = 1'b1;
      step();
      checks++;
      if (ma_alu_result !== 32'h10 || ma_rd !== 5'd3 || ma_valid !== 1'b1 || ma_reg_write !== 1'b1) begin
         errors++; $display("FAIL plain_load got alu=%h rd=%0d v=%b rw=%b want 10/3/1/1",
                            ma_alu_result, ma_rd, ma_valid, ma_reg_write);
      end
      checks++;
      if (obs_vec !== exp_vec()) begin
         errors++; $display("FAIL plain_load_vec got %h want %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_beq();
      drive_clear_ex();
      ex_valid = 1'b1; ex_addr_sel = 3'd2; ex_zero = 1'b1; ex_branch_target = 32'h40;
      ex_alu_result = 32'h0;
      step();
      checks++;
      if (addr_sel_out !== 3'd2 || redirect_pc !== 32'h40 || zero_out !== 1'b1) begin
         errors++; $display("FAIL beq_taken got sel=%0d pc=%h z=%b want 2/40/1",
                            addr_sel_out, redirect_pc, zero_out);
      end
      flush_in = 1'b1;
      drive_random_ex();
      step();
      flush_in = 1'b0;
      checks++;
      if (ma_valid !== 1'b0 || addr_sel_out !== 3'd0 || zero_out !== 1'b0 || ma_reg_write !== 1'b0) begin
         errors++; $display("FAIL beq_flush got v=%b sel=%0d z=%b rw=%b want 0/0/0/0",
                            ma_valid, addr_sel_out, zero_out, ma_reg_write);
      end
      checks++;
      if (obs_vec !== exp_vec()) begin
         errors++; $display("FAIL beq_flush_vec got %h want %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_jalr();
      drive_clear_ex();
      ex_valid = 1'b1; ex_addr_sel = 3'd4; ex_alu_result = 32'h1003;
      ex_pc_plus4 = 32'h0000_2004; ex_branch_target = 32'h0000_0BAD;
      ex_reg_write = 1'b1; ex_wb_sel = 2'd2; ex_rd = 5'd1;
      step();
      checks++;
      if (redirect_pc !== 32'h1002 || ma_pc_plus4 !== 32'h2004 || addr_sel_out !== 3'd4) begin
         errors++; $display("FAIL jalr got pc=%h link=%h sel=%0d want 1002/2004/4",
                            redirect_pc, ma_pc_plus4, addr_sel_out);
      end
   endtask

   task automatic test_stall();
      logic [143:0] held;
      drive_random_ex();
      ex_valid = 1'b1; ex_addr_sel = 3'd1; ex_less = 1'b1;
      step();
      held = exp_vec();
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_random_ex();
         step();
         checks++;
         if (obs_vec !== held) begin
            errors++; $display("FAIL stall_hold_%0d got %h want %h", i, obs_vec, held);
         end
      end
      flush_in = 1'b1;
      step();
      flush_in = 1'b0; stall_in = 1'b0;
      checks++;
      if (ma_valid !== 1'b0 || addr_sel_out !== 3'd0 || less_out !== 1'b0 || obs_vec !== exp_vec()) begin
         errors++; $display("FAIL stall_flush got %h want %h", obs_vec, exp_vec());
      end
   endtask

   task automatic test_bubble_input();
      drive_random_ex();
      ex_valid = 1'b0; ex_addr_sel = 3'd3; ex_reg_write = 1'b1; ex_mem_write = 1'b1;
      step();
      checks++;
      if (addr_sel_out !== 3'd0 || ma_valid !== 1'b0 || ma_reg_write !== 1'b0 || ma_mem_write !== 1'b0) begin
         errors++; $display("FAIL bubble_input got sel=%0d v=%b rw=%b mw=%b want 0/0/0/0",
                            addr_sel_out, ma_valid, ma_reg_write, ma_mem_write);
      end
   endtask

   task automatic test_reset_mid();
      drive_clear_ex();
      ex_valid = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_alu_result = 32'h1234;
      step();
      #2;
      rstn = 1'b0;
      model_bubble(); m_redir = 0; m_stall = 0;
      #1;
      checks++;
      if (obs_vec !== 144'd0) begin
         errors++; $display("FAIL reset_mid got %h want 0", obs_vec);
      end
`ifdef EXMA_PERF_CNT_EN
      checks++;
      if (perf_redirects !== 32'd0 || perf_stalls !== 32'd0) begin
         errors++; $display("FAIL reset_mid_perf got %0d/%0d want 0/0", perf_redirects, perf_stalls);
      end
`endif
      #1;
      rstn = 1'b1;
   endtask

`ifdef EXMA_PERF_CNT_EN
   task automatic test_perf();
      rstn = 1'b0; m_redir = 0; m_stall = 0; model_bubble();
      #2; rstn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         flush_in = 1'b1; drive_random_ex(); step();
      end
      flush_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         stall_in = 1'b1; drive_random_ex(); step();
      end
      stall_in = 1'b0;
      checks++;
      if (perf_redirects !== 32'd2 || perf_stalls !== 32'd3) begin
         errors++; $display("FAIL perf_counts got %0d/%0d want 2/3", perf_redirects, perf_stalls);
      end
      for (int i = 0; i < 2; i++) begin
         flush_in = 1'b1; stall_in = 1'b1; step();
      end
      flush_in = 1'b0; stall_in = 1'b0;
      checks++;
      if (perf_redirects2 !== 2'd0 || perf_stalls2 !== 2'd3 || perf_redirects !== 32'd4) begin
         errors++; $display("FAIL perf_wrap got %0d/%0d/%0d want 0/3/4",
                            perf_redirects2, perf_stalls2, perf_redirects);
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_random_ex();
         flush_in = ($urandom_range(0, 7) == 0);
         stall_in = ($urandom_range(0, 3) == 0);
         step();
         checks++;
         if (obs_vec !== exp_vec()) begin
            errors++; $display("FAIL random_%0d got %h want %h", i, obs_vec, exp_vec());
         end
`ifdef EXMA_PERF_CNT_EN
         checks++;
         if (perf_redirects !== m_redir || perf_stalls !== m_stall ||
             perf_redirects2 !== 2'(m_redir) || perf_stalls2 !== 2'(m_stall)) begin
            errors++; $display("FAIL random_perf_%0d got %0d/%0d want %0d/%0d",
                               i, perf_redirects, perf_stalls, m_redir, m_stall);
         end
`endif
      end
      flush_in = 1'b0; stall_in = 1'b0;
   endtask

   initial begin
      test_reset();
      test_plain_load();
      test_beq();
      test_jalr();
      test_stall();
      test_bubble_input();
      test_reset_mid();
`ifdef EXMA_PERF_CNT_EN
      test_perf();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
